// File: rtl/fetch_controller.sv
// Instruction fetch controller with a two-entry fetch buffer.
//
// A single read is kept in flight against an instruction memory whose data is
// valid RD_LAT cycles after the address is presented. Captured words are queued
// together with their fetch address and handed to decode through a
// valid/ready pair.
//
// Handshake: instr_valid_o is high whenever the buffer head holds an
// instruction; the head is consumed at the rising edge where both
// instr_valid_o and decode_ready_i are high. instr_o/instr_pc_o stay stable
// while instr_valid_o is high and decode_ready_i is low.
//
// dbg_state_o exposes the FSM state: 0 = IDLE, 1 = WAIT, 2 = HOLD.
module fetch_controller #(
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] start_pc_i,
    output logic [63:0] imem_address_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        decode_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] instr_pc_o,
    output logic        fetch_busy_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Wait counter reload value: the capture happens when the counter hits 0,
    // so a read launched with RD_LAT-1 completes after RD_LAT cycles.
    localparam logic [3:0] CNT_RELOAD = 4'(RD_LAT - 1);
    localparam logic [1:0] BUF_FULL   = 2'(BUF_DEPTH);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  occ_q, occ_d;
    logic        head_q, head_d;
    logic [31:0] buf_instr_q [2];
    logic [63:0] buf_pc_q    [2];

    logic        pop;
    logic        can_capture;
    logic        do_push;
    logic        do_pop;
    logic        flush;
    logic        wr_idx;

    // The two address LSBs are forced to zero; only the word address is used.
    logic unused_low_bits;
    assign unused_low_bits = ^{start_pc_i[1:0], redirect_pc_i[1:0]};

    assign pop         = instr_valid_o && decode_ready_i;
    // A full buffer can still accept a capture if its head leaves this cycle.
    assign can_capture = (occ_q < BUF_FULL) || pop;
    // Tail slot: with two entries head+occupancy wraps back onto the head,
    // which is only written when that head is popped in the same cycle.
    assign wr_idx      = head_q ^ occ_q[0];

    // FSM state register and fetch PC / wait counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= 64'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a redirect overrides everything the state would do.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        do_push = 1'b0;
        do_pop  = 1'b0;
        flush   = 1'b0;
        if (redirect_i) begin
            flush   = 1'b1;
            pc_d    = {redirect_pc_i[63:2], 2'b00};
            cnt_d   = CNT_RELOAD;
            state_d = ST_WAIT;
        end else begin
            do_pop = pop;
            case (state_q)
                ST_IDLE: begin
                    pc_d    = {start_pc_i[63:2], 2'b00};
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (can_capture) begin
                        do_push = 1'b1;
                        pc_d    = pc_q + 64'd4;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        // No room: drop this read and re-issue it later.
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (occ_q < BUF_FULL) begin
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Buffer occupancy and head pointer bookkeeping.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        if (flush) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
        end else begin
            if (do_pop) begin
                head_d = ~head_q;
            end
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Fetch buffer storage; reset clears contents so outputs read as zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_q  <= 2'd0;
            head_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr_q[i] <= 32'd0;
                buf_pc_q[i]    <= 64'd0;
            end
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            if (do_push) begin
                buf_instr_q[wr_idx] <= imem_data_i;
                buf_pc_q[wr_idx]    <= pc_q;
            end
        end
    end

    assign imem_address_o = pc_q;
    assign instr_valid_o  = (occ_q != 2'd0);
    assign instr_o        = buf_instr_q[head_q];
    assign instr_pc_o     = buf_pc_q[head_q];
    assign fetch_busy_o   = (state_q == ST_WAIT);
    assign dbg_state_o    = state_q;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RD_LAT, default 2, meaning instruction-memory read latency in cycles (legal 1..15).
REQ-002 Parameter BUF_DEPTH, fixed 2, meaning fetch-buffer entries.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 StartPC  input  64  PC loaded on the first cycle after reset.
REQ-006 IMemAddress  output  64  address driven to InstructionMemory.
REQ-007 IMemData  input  32  instruction word returned by InstructionMemory.
REQ-008 Redirect  input  1  branch/CBZ-taken pulse; flushes and restarts fetch.
REQ-009 RedirectPC  input  64  new fetch PC, valid when Redirect=1.
REQ-010 DecodeReady  input  1  decode stage accepts Instr this cycle.
REQ-011 InstrValid  output  1  buffer head holds a valid instruction.
REQ-012 Instr  output  32  buffer-head instruction word.
REQ-013 InstrPC  output  64  address the buffer-head instruction was fetched from.
REQ-014 FetchBusy  output  1  a memory read is in flight.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and HOLD.
REQ-016 IDLE: one cycle only; loads PC := {StartPC[63:2],2'b00} and wait counter := RD_LAT-1; next state WAIT.
REQ-017 WAIT: IMemAddress = PC, held stable; the counter decrements each cycle; when counter==0, IMemData is captured this cycle.
REQ-018 Capture SHALL occur only if occupancy<2, or occupancy==2 with a pop in the same cycle; otherwise the FSM goes to HOLD, PC unchanged.
REQ-019 On capture: push {IMemData, PC}; PC := PC+4 (mod 2^64, wraps to 0); counter := RD_LAT-1; stay in WAIT.
REQ-020 HOLD: IMemAddress = PC; return to WAIT with counter := RD_LAT-1 once occupancy<2 (re-read; no stale data is used).
REQ-021 Pop: when InstrValid && DecodeReady, the head entry is removed at the clock edge; Instr/InstrPC show the next entry the following cycle.
REQ-022 Simultaneous push and pop SHALL keep occupancy constant and preserve FIFO order.
REQ-023 InstrValid = (occupancy>0); Instr/InstrPC SHALL hold their values while InstrValid && !DecodeReady.
REQ-024 Redirect (any state) SHALL take priority: flush buffer (occupancy:=0), discard in-flight read and any same-cycle capture or pop, PC := {RedirectPC[63:2],2'b00}, counter := RD_LAT-1, next state WAIT.
REQ-025 InstrValid SHALL be 0 in the cycle after Redirect; the first post-redirect instruction appears RD_LAT cycles after the Redirect edge.
REQ-026 Steady-state throughput SHALL be one instruction per RD_LAT cycles with DecodeReady held high.
REQ-027 FetchBusy = 1 in WAIT, 0 in IDLE and HOLD.
REQ-028 RTL SHALL be fully synchronous; IMemData is sampled only on the capture edge.

Reset
REQ-029 While Reset=1: state:=IDLE, PC:=0, occupancy:=0, counter:=0, buffer contents:=0.
REQ-030 Outputs during/immediately after reset: IMemAddress=0, InstrValid=0, Instr=0, InstrPC=0, FetchBusy=0.
REQ-031 Reset asserted mid-read or with a full buffer SHALL discard everything; no pop or capture takes effect in a reset cycle.
REQ-032 Reset SHALL override Redirect in the same cycle.

Verification
REQ-033 Reset, StartPC=0, RD_LAT=2, DecodeReady=1, InstructionMemory attached -> InstrValid first high 3 cycles after reset release, Instr=F84003E9 InstrPC=0, then F84083EA InstrPC=4 two cycles later.
REQ-034 DecodeReady=0 from release -> two entries (F84003E9 @0, F84083EA @4) buffered, FSM enters HOLD with IMemAddress=8, FetchBusy=0; raise DecodeReady -> F84103EB @8 follows in order, no gaps or duplicates.
REQ-035 Buffer holding 2 entries, Redirect=1 RedirectPC=0x1C -> next cycle InstrValid=0, IMemAddress=0x1C; 2 cycles later Instr=B400008C InstrPC=0x1C.
REQ-036 Redirect and DecodeReady pop in the same cycle with a capture due -> pop and capture discarded, occupancy=0, PC=RedirectPC; RedirectPC=0x2E -> PC=0x2C.
REQ-037 StartPC=0xFFFFFFFFFFFFFFFC -> after one capture IMemAddress wraps to 0.
REQ-038 Reset asserted during WAIT with occupancy 1 -> next cycle all outputs at reset values, then fetch restarts from StartPC.
